uart_8250_tx_ctrl: RTL and testbench

Wishbone master that brings up the 8250-style UART and streams bytes into it. It sits between a byte-stream producer (valid/ready) and the UART's Wishbone slave port. The controller programs the divisor, line format, FIFOs and interrupt enable, then feeds the transmit FIFO in bursts. It paces the bursts with the UART's THR-empty interrupt, so the UART FIFO never overflows.

---
 rtl/uart_8250_tx_ctrl_if.sv | 21 ++
 rtl/uart_8250_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_8250_tx_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_8250_tx_ctrl_if.sv
// rtl/uart_8250_tx_ctrl_if.sv - Wishbone bundle between the TX controller and the 8250 UART slave port
interface uart_8250_tx_ctrl_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        WE_O;
  logic [3:0]  SEL_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;

  modport master (
    output ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/uart_8250_tx_ctrl.sv
// rtl/uart_8250_tx_ctrl.sv - Wishbone master that initialises an 8250 UART and feeds its TX FIFO
// in bursts, paced by the THR-empty interrupt.
module uart_8250_tx_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h1250_0000,
  parameter int          BURST       = 16,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          INT_TIMEOUT = 65535
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  uart_8250_tx_ctrl_if.master        wb,
  input  logic                       UART_INT_I,
  input  logic                       start_i,
  input  logic [15:0]                divisor_i,
  input  logic [7:0]                 tx_data_i,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  output logic                       busy_o,
  output logic                       err_o
);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int IW = $clog2(INT_TIMEOUT + 1);
  localparam logic [4:0] BURST_L = 5'(BURST);

  typedef enum logic [3:0] {
    IDLE, I_DLAB, I_DLL, I_DLM, I_LCR, I_FCR, I_IER, READY, W_THR, W_INT, R_IIR, ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    byte_q, byte_d;
  logic [4:0]    burst_cnt_q, burst_cnt_d;
  logic [AW-1:0] ack_cnt_q, ack_cnt_d;
  logic [IW-1:0] int_cnt_q, int_cnt_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;

  logic          access, acc_we;
  logic [1:0]    acc_off;
  logic [7:0]    acc_dat;
  logic          ack_hit, ack_expired;
  logic          unused_dat;

  // IIR contents are not needed; the read exists only to clear the UART interrupt.
  assign unused_dat = ^wb.DAT_I;

  always_comb begin : access_decode
    access  = 1'b1;
    acc_we  = 1'b1;
    acc_off = 2'd0;
    acc_dat = 8'h00;
    unique case (state_q)
      I_DLAB: begin acc_off = 2'd3; acc_dat = 8'h83;        end
      I_DLL:  begin acc_off = 2'd0; acc_dat = div_q[7:0];   end
      I_DLM:  begin acc_off = 2'd1; acc_dat = div_q[15:8];  end
      I_LCR:  begin acc_off = 2'd3; acc_dat = 8'h03;        end
      I_FCR:  begin acc_off = 2'd2; acc_dat = 8'h07;        end
      I_IER:  begin acc_off = 2'd1; acc_dat = 8'h02;        end
      W_THR:  begin acc_off = 2'd0; acc_dat = byte_q;       end
      R_IIR:  begin acc_off = 2'd2; acc_we  = 1'b0;         end
      default: begin access = 1'b0; acc_we = 1'b0;          end
    endcase
  end

  // An ACK only counts while our strobe is up; the slave's trailing ACK is ignored.
  assign ack_hit     = stb_q && (wb.ACK_I == 1'b1);
  assign ack_expired = stb_q && !ack_hit && (ack_cnt_q == AW'(ACK_TIMEOUT - 1));

  always_comb begin : next_state
    state_d     = state_q;
    div_d       = div_q;
    byte_d      = byte_q;
    burst_cnt_d = burst_cnt_q;
    ack_cnt_d   = '0;
    int_cnt_d   = '0;
    stb_d       = 1'b0;
    we_d        = 1'b0;
    adr_d       = '0;
    dat_d       = '0;

    if (access && !ack_hit && !ack_expired) begin
      stb_d = 1'b1;
      we_d  = acc_we;
      adr_d = BASE_ADDR + {30'd0, acc_off};
      dat_d = acc_we ? acc_dat : 8'h00;
    end
    if (stb_q && !ack_hit && !ack_expired) ack_cnt_d = ack_cnt_q + 1'b1;

    unique case (state_q)
      IDLE, ERROR: begin
        if (start_i) begin
          div_d   = divisor_i;
          state_d = I_DLAB;
        end
      end
      READY: begin
        if (tx_valid_i && tx_ready_o) begin
          byte_d  = tx_data_i;
          state_d = W_THR;
        end
      end
      W_INT: begin
        if (UART_INT_I) state_d = R_IIR;
        else if (int_cnt_q == IW'(INT_TIMEOUT - 1)) state_d = ERROR;
        else int_cnt_d = int_cnt_q + 1'b1;
      end
      default: ;
    endcase

    if (ack_expired) begin
      state_d = ERROR;
    end else if (ack_hit) begin
      unique case (state_q)
        I_DLAB: state_d = I_DLL;
        I_DLL:  state_d = I_DLM;
        I_DLM:  state_d = I_LCR;
        I_LCR:  state_d = I_FCR;
        I_FCR:  state_d = I_IER;
        I_IER:  begin state_d = READY; burst_cnt_d = '0; end
        W_THR:  begin
          burst_cnt_d = burst_cnt_q + 5'd1;
          state_d     = (burst_cnt_q + 5'd1 == BURST_L) ? W_INT : READY;
        end
        R_IIR:  begin state_d = READY; burst_cnt_d = '0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q     <= IDLE;
      div_q       <= '0;
      byte_q      <= '0;
      burst_cnt_q <= '0;
      ack_cnt_q   <= '0;
      int_cnt_q   <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      byte_q      <= byte_d;
      burst_cnt_q <= burst_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      int_cnt_q   <= int_cnt_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

  assign wb.ADR_O   = adr_q;
  assign wb.DAT_O   = {24'd0, dat_q};
  assign wb.WE_O    = we_q;
  assign wb.SEL_O   = {3'b000, stb_q};
  assign wb.STB_O   = stb_q;
  assign wb.CYC_O   = stb_q;

  assign tx_ready_o = (state_q == READY) && (burst_cnt_q < BURST_L);
  assign busy_o     = !(state_q == IDLE || state_q == READY || state_q == ERROR);
  assign err_o      = (state_q == ERROR);
endmodule

// File: tb/tb_uart_8250_tx_ctrl.sv
// tb/tb_uart_8250_tx_ctrl.sv - Directed and randomized bench for uart_8250_tx_ctrl with a UART slave model
module tb_uart_8250_tx_ctrl;
  localparam logic [31:0] BASE   = 32'h1250_0000;
  localparam int          BURST  = 4;
  localparam int          INT_TO = 100;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        UART_INT_I;
  logic        start_i;
  logic [15:0] divisor_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        busy_o;
  logic        err_o;

  uart_8250_tx_ctrl_if bus();

  uart_8250_tx_ctrl #(
    .BASE_ADDR(BASE), .BURST(BURST), .ACK_TIMEOUT(255), .INT_TIMEOUT(INT_TO)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .wb(bus), .UART_INT_I(UART_INT_I),
    .start_i(start_i), .divisor_i(divisor_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial forever #5 CLK_I = ~CLK_I;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK_I) cyc <= cyc + 1;

  // UART slave: registered ACK (so it lingers one cycle after STB falls), THR-empty interrupt
  // raised some cycles after each THR write, cleared by a THR write or an IIR read.
  bit   ack_en = 1'b1;
  bit   int_en = 1'b1;
  logic ack_q;
  logic int_pend;
  int   drain;
  always @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ack_q <= 1'b0; int_pend <= 1'b0; drain <= 0;
    end else begin
      ack_q <= bus.STB_O & ack_en;
      if (bus.STB_O && ack_q && bus.WE_O && bus.ADR_O == BASE) begin
        int_pend <= 1'b0; drain <= int'($urandom_range(30, 5));
      end else if (bus.STB_O && ack_q && !bus.WE_O && bus.ADR_O == BASE + 32'd2) begin
        int_pend <= 1'b0;
      end else if (drain > 0) begin
        drain <= drain - 1;
        if (drain == 1) int_pend <= 1'b1;
      end
    end
  end
  assign bus.ACK_I  = ack_q;
  assign bus.DAT_I  = 32'h0000_00C2;
  assign UART_INT_I = int_pend & int_en;

  function automatic int enc(input bit we, input int off, input int dat);
    return (we ? 32'h10000 : 0) | (off << 8) | (dat & 255);
  endfunction

  int   log_q[$];
  int   exp_q[$];
  int   thr_cyc[$];
  int   run = 0, last_run = 0, bad_proto = 0, bad_gap = 0;
  logic prev_hit = 1'b0, prev_stb = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(negedge CLK_I) begin
    if (bus.STB_O === 1'b1) begin
      run++;
      if (bus.SEL_O !== 4'b0001 || bus.CYC_O !== 1'b1 || bus.DAT_O[31:8] !== 24'h0) bad_proto++;
      if (prev_hit) bad_gap++;
      if (prev_stb && !prev_ack &&
          (bus.ADR_O !== prev_adr || bus.DAT_O !== prev_dat || bus.WE_O !== prev_we)) bad_proto++;
      if (bus.ACK_I === 1'b1) begin
        log_q.push_back(enc(bus.WE_O, int'(bus.ADR_O - BASE), bus.WE_O ? int'(bus.DAT_O[7:0]) : 0));
        if (bus.WE_O && bus.ADR_O == BASE) thr_cyc.push_back(cyc);
      end
    end else begin
      if (run > 0) last_run = run;
      run = 0;
      if (bus.SEL_O !== 4'b0000 || bus.CYC_O !== 1'b0) bad_proto++;
    end
    prev_hit = (bus.STB_O === 1'b1) && (bus.ACK_I === 1'b1);
    prev_stb = bus.STB_O;
    prev_ack = bus.ACK_I;
    prev_adr = bus.ADR_O;
    prev_dat = bus.DAT_O;
    prev_we  = bus.WE_O;
  end

  int cnt_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init(input logic [15:0] d);
    exp_q.push_back(enc(1, 3, 'h83));
    exp_q.push_back(enc(1, 0, int'(d[7:0])));
    exp_q.push_back(enc(1, 1, int'(d[15:8])));
    exp_q.push_back(enc(1, 3, 'h03));
    exp_q.push_back(enc(1, 2, 'h07));
    exp_q.push_back(enc(1, 1, 'h02));
    cnt_model = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit int_read);
    exp_q.push_back(enc(1, 0, int'(b)));
    cnt_model++;
    if (cnt_model == BURST) begin
      if (int_read) exp_q.push_back(enc(0, 2, 0));
      cnt_model = 0;
    end
  endtask

  task automatic clear_logs();
    log_q.delete(); exp_q.delete(); thr_cyc.delete();
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    for (int n = 0; n < 600 && !ok; n++) begin
      if (tx_ready_o === 1'b1) ok = 1'b1;
      @(negedge CLK_I);
    end
    tx_valid_i = 1'b0;
    chk("send_handshake", ok, 1'b1);
  endtask

  task automatic start_pulse(input logic [15:0] d);
    divisor_i = d;
    start_i   = 1'b1;
    @(negedge CLK_I);
    start_i   = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy_o === 1'b1 && n < bound) begin
      n++;
      @(negedge CLK_I);
    end
    chk("idle_bound", busy_o, 1'b0);
  endtask

  task automatic wait_err(input int bound, output int at_cyc);
    int n = 0;
    while (err_o !== 1'b1 && n < bound) begin
      n++;
      @(negedge CLK_I);
    end
    at_cyc = cyc;
    chk("err_bound", err_o, 1'b1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_adr"}, bus.ADR_O, 32'h0);
    chk({tag, "_dat"}, bus.DAT_O, 32'h0);
    chk({tag, "_we"}, bus.WE_O, 1'b0);
    chk({tag, "_sel"}, bus.SEL_O, 4'h0);
    chk({tag, "_stb"}, bus.STB_O, 1'b0);
    chk({tag, "_cyc"}, bus.CYC_O, 1'b0);
    chk({tag, "_ready"}, tx_ready_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
  endtask

  initial begin
    int n;
    int at;
    int need;
    logic [15:0] d;
    logic [7:0]  b;

    RST_I = 1'b0; start_i = 1'b0; divisor_i = '0; tx_data_i = '0; tx_valid_i = 1'b0;
    repeat (3) @(negedge CLK_I);
    chk_reset_outs("reset");
    RST_I = 1'b1;
    @(negedge CLK_I);

    // Init with the reference divisor
    clear_logs();
    model_init(16'h0145);
    start_pulse(16'h0145);
    wait_idle(200, n);
    chk("init_cycles", n, 18);
    chk("init_ready", tx_ready_o, 1'b1);
    chk("init_err", err_o, 1'b0);
    cmp_log("init");

    // Burst pacing: six back-to-back bytes
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      model_byte(b, 1'b1);
      send_byte(b);
    end
    wait_idle(400, n);
    cmp_log("burst");
    chk("thr_count", thr_cyc.size(), 6);
    chk("b2b_gap", (thr_cyc.size() > 1) ? thr_cyc[1] - thr_cyc[0] : 0, 4);

    // Random bytes with producer stalls
    clear_logs();
    for (int i = 0; i < 11; i++) begin
      b = 8'($urandom);
      model_byte(b, 1'b1);
      send_byte(b);
      repeat ($urandom_range(3, 0)) @(negedge CLK_I);
    end
    wait_idle(400, n);
    cmp_log("rand");
    chk("rand_ready", tx_ready_o, 1'b1);

    // Interrupt never arrives after a full burst
    int_en = 1'b0;
    clear_logs();
    need = BURST - cnt_model;
    for (int i = 0; i < need; i++) begin
      b = 8'($urandom);
      model_byte(b, 1'b0);
      send_byte(b);
    end
    wait_err(400, at);
    chk("int_timeout_wait", at - ((thr_cyc.size() > 0) ? thr_cyc[thr_cyc.size() - 1] : 0) - 1, INT_TO);
    chk("int_to_ready", tx_ready_o, 1'b0);
    chk("int_to_busy", busy_o, 1'b0);
    chk("int_to_stb", bus.STB_O, 1'b0);
    cmp_log("int_to");
    int_en = 1'b1;

    // Recovery from ERROR with a random divisor
    clear_logs();
    d = 16'($urandom);
    model_init(d);
    start_pulse(d);
    chk("restart_err_clr", err_o, 1'b0);
    wait_idle(200, n);
    chk("restart_cycles", n, 18);
    cmp_log("restart");

    // start_i in READY is ignored
    clear_logs();
    start_pulse(16'h1234);
    repeat (5) @(negedge CLK_I);
    chk("ign_start_busy", busy_o, 1'b0);
    chk("ign_start_log", log_q.size(), 0);
    chk("ign_start_ready", tx_ready_o, 1'b1);

    // Stalled ACK on a THR write, then on the first init write
    ack_en = 1'b0;
    clear_logs();
    send_byte(8'h5A);
    wait_err(600, at);
    @(negedge CLK_I);
    chk("stall_thr_run", last_run, 255);
    chk("stall_thr_stb", bus.STB_O, 1'b0);
    chk("stall_thr_log", log_q.size(), 0);
    start_pulse(16'h0145);
    chk("stall_start_err", err_o, 1'b0);
    wait_err(600, at);
    @(negedge CLK_I);
    chk("stall_init_run", last_run, 255);
    chk("stall_init_ready", tx_ready_o, 1'b0);
    ack_en = 1'b1;
    clear_logs();
    d = 16'($urandom);
    model_init(d);
    start_pulse(d);
    wait_idle(200, n);
    cmp_log("stall_reinit");

    // Reset while a THR write is on the bus
    send_byte(8'hC3);
    @(negedge CLK_I);
    chk("pre_reset_stb", bus.STB_O, 1'b1);
    #2 RST_I = 1'b0;
    #1 chk_reset_outs("async_rst");
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (5) @(negedge CLK_I);
    chk("post_rst_ready", tx_ready_o, 1'b0);
    chk("post_rst_busy", busy_o, 1'b0);
    clear_logs();
    d = 16'($urandom);
    model_init(d);
    start_pulse(d);
    wait_idle(200, n);
    chk("post_rst_init_ready", tx_ready_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      model_byte(b, 1'b1);
      send_byte(b);
    end
    wait_idle(400, n);
    cmp_log("post_rst");

    chk("protocol_errors", bad_proto, 0);
    chk("idle_gap_errors", bad_gap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
